// File: rtl/adc_pkg.sv
// Shared ADC definitions: SAR state encoding and default sizing.
package adc_pkg;

   localparam int ADC_WIDTH             = 8;
   localparam int DEFAULT_SETTLE_CYCLES = 1000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET_BIT = 3'd1,
      SETTLE  = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } sar_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit (comparator inputs).
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   // Shift the raw input through two flops to resolve metastability.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/r2r_sar_controller.sv
// Successive-approximation engine for the R2R ladder ADC: drives the ladder
// code MSB first, samples the synchronized comparator, publishes the result.
// SETTLE_CYCLES must be at least 3 so the 2-flop sync sees the settled ladder.
module r2r_sar_controller
   import adc_pkg::*;
#(
   parameter int WIDTH         = ADC_WIDTH,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             start,
   input  logic             continuous,
   input  logic             comparator_in,
   output logic [WIDTH-1:0] dac_code,
   output logic [WIDTH-1:0] r2r_successive_out,
   output logic             result_valid,
   output logic             busy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   sar_state_t       state_reg;
   sar_state_t       state_next;
   logic [IDX_W-1:0] idx_reg;
   logic [WIDTH-1:0] trial_reg;
   logic [WIDTH-1:0] result_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             valid_reg;
   logic             comp_sync;
   logic [WIDTH-1:0] bit_mask;

   sync_2ff u_comp_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (comparator_in),
      .q       (comp_sync)
   );

   // One-hot mask of the bit currently under trial.
   assign bit_mask = ONE << idx_reg;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; dropping enable aborts from any state back to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable && (start || continuous)) state_next = SET_BIT;
         SET_BIT: state_next = SETTLE;
         SETTLE:  if (cnt_reg == CNT_LAST) state_next = COMPARE;
         COMPARE: state_next = (idx_reg == '0) ? DONE : SET_BIT;
         DONE:    state_next = (enable && continuous) ? SET_BIT : IDLE;
         default: state_next = IDLE;
      endcase
      if (!enable) begin
         state_next = IDLE;
      end
   end

   // Trial/index/counter datapath and the held result register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_reg    <= IDX_MSB;
         trial_reg  <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         valid_reg  <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               idx_reg   <= IDX_MSB;
               trial_reg <= '0;
            end
            SET_BIT: begin
               cnt_reg <= '0;
            end
            SETTLE: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            COMPARE: begin
               // Keep the trial bit only when Vin >= Vdac.
               if (comp_sync) begin
                  trial_reg <= trial_reg | bit_mask;
               end
               if (idx_reg != '0) begin
                  idx_reg <= idx_reg - IDX_W'(1);
               end
            end
            DONE: begin
               // An abort landing on DONE must not publish a result.
               if (enable) begin
                  result_reg <= trial_reg;
                  valid_reg  <= 1'b1;
               end
               idx_reg   <= IDX_MSB;
               trial_reg <= '0;
            end
            default: begin
               idx_reg   <= IDX_MSB;
               trial_reg <= '0;
            end
         endcase
      end
   end

   // Ladder code and busy flag decoded from the current state.
   always_comb begin
      dac_code = '0;
      busy     = 1'b0;
      case (state_reg)
         SET_BIT, SETTLE, COMPARE: begin
            dac_code = trial_reg | bit_mask;
            busy     = 1'b1;
         end
         DONE:    dac_code = trial_reg;
         default: dac_code = '0;
      endcase
   end

   assign r2r_successive_out = result_reg;
   assign result_valid       = valid_reg;

endmodule

// File: tb/tb_r2r_sar_controller.sv
// Bench for r2r_sar_controller with a fast settle time and an ideal comparator.
module tb_r2r_sar_controller;

   localparam int W   = 8;
   localparam int SC  = 4;
   localparam int LAT = W * (SC + 2) + 1;   // 49 clocks start->valid, also the continuous period

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b1;
   logic         start = 1'b0;
   logic         continuous = 1'b0;
   logic [W-1:0] vin_code = '0;
   logic         comparator_in;
   logic [W-1:0] dac_code;
   logic [W-1:0] r2r_successive_out;
   logic         result_valid;
   logic         busy;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           valid_count = 0;
   int           last_valid_cyc = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;

   r2r_sar_controller #(
      .WIDTH         (W),
      .SETTLE_CYCLES (SC)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .enable             (enable),
      .start              (start),
      .continuous         (continuous),
      .comparator_in      (comparator_in),
      .dac_code           (dac_code),
      .r2r_successive_out (r2r_successive_out),
      .result_valid       (result_valid),
      .busy               (busy)
   );

   // Ideal comparator: 1 when Vin >= Vdac.
   assign comparator_in = (vin_code >= dac_code);

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Scoreboard: every result_valid pops one expected result.
   always @(posedge clk) begin
      #1;
      if (result_valid === 1'b1) begin
         valid_count++;
         last_valid_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected got=%02h required=none cycle=%0d", r2r_successive_out, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (r2r_successive_out !== mon_exp) begin
               errors++;
               $display("FAIL result_value got=%02h required=%02h cycle=%0d", r2r_successive_out, mon_exp, cyc);
            end else begin
               $display("result %02h at cycle %0d", r2r_successive_out, cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Waits (bounded) for the next result_valid; returns whether it came and when.
   task automatic wait_valid(output bit got, output int at_cyc);
      int n0;
      int t;
      n0 = valid_count;
      t  = 0;
      while (valid_count == n0 && t < 200) begin
         tick(1);
         t++;
      end
      got    = (valid_count != n0);
      at_cyc = last_valid_cyc;
   endtask

   task automatic start_conv(output int k);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      k = cyc;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if (dac_code !== 8'h00) begin errors++; $display("FAIL reset_dac got=%02h required=00", dac_code); end
      checks++;
      if (r2r_successive_out !== 8'h00) begin errors++; $display("FAIL reset_out got=%02h required=00", r2r_successive_out); end
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", result_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_trial_sequence;
      logic [W-1:0] seq [8];
      int  k;
      int  at;
      bit  got;
      seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      vin_code = 8'hA5;
      exp_q.push_back(8'hA5);
      start_conv(k);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dac_code !== seq[i]) begin
            errors++;
            $display("FAIL trial_code_%0d got=%02h required=%02h", i, dac_code, seq[i]);
         end
         if (i == 0) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL trial_busy got=%b required=1", busy); end
         end
         tick(6);
      end
      checks++;
      if (dac_code !== 8'hA5 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_code got=%02h/busy=%b required=a5/busy=0", dac_code, busy);
      end
      wait_valid(got, at);
      checks++;
      if (!got || (at - k) != LAT) begin
         errors++;
         $display("FAIL latency_a5 got=%0d required=%0d", got ? at - k : -1, LAT);
      end
      tick(1);
      checks++;
      if (result_valid !== 1'b0 || dac_code !== 8'h00) begin
         errors++;
         $display("FAIL valid_pulse_width got=valid%b/dac%02h required=valid0/dac00", result_valid, dac_code);
      end
      tick(3);
   endtask

   task automatic test_boundaries;
      logic [W-1:0] vals [2];
      int  k;
      int  at;
      bit  got;
      vals = '{8'h00, 8'hFF};
      for (int i = 0; i < 2; i++) begin
         vin_code = vals[i];
         exp_q.push_back(vals[i]);
         start_conv(k);
         wait_valid(got, at);
         checks++;
         if (!got || (at - k) != LAT) begin
            errors++;
            $display("FAIL latency_bound_%02h got=%0d required=%0d", vals[i], got ? at - k : -1, LAT);
         end
         checks++;
         if (busy !== 1'b0 || dac_code !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_%02h got=busy%b/dac%02h required=busy0/dac00", vals[i], busy, dac_code);
         end
         tick(3);
      end
   endtask

   task automatic test_continuous;
      int  k;
      int  a1;
      int  a2;
      int  a3;
      int  a4;
      int  n0;
      bit  got;
      vin_code = 8'h3C;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h3C);
      continuous = 1'b1;
      @(posedge clk);
      #2;
      k = cyc;
      wait_valid(got, a1);
      checks++;
      if (!got || (a1 - k) != LAT) begin errors++; $display("FAIL cont_first got=%0d required=%0d", got ? a1 - k : -1, LAT); end
      wait_valid(got, a2);
      checks++;
      if (!got || (a2 - a1) != LAT) begin errors++; $display("FAIL cont_period_1 got=%0d required=%0d", got ? a2 - a1 : -1, LAT); end
      // The conversion starting at this pulse is the first to see the new input.
      vin_code = 8'h81;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h81);
      wait_valid(got, a3);
      checks++;
      if (!got || (a3 - a2) != LAT) begin errors++; $display("FAIL cont_period_2 got=%0d required=%0d", got ? a3 - a2 : -1, LAT); end
      tick(10);
      continuous = 1'b0;
      wait_valid(got, a4);
      checks++;
      if (!got || (a4 - a3) != LAT) begin errors++; $display("FAIL cont_finish got=%0d required=%0d", got ? a4 - a3 : -1, LAT); end
      n0 = valid_count;
      tick(60);
      checks++;
      if (valid_count != n0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop got=extra%0d/busy%b required=extra0/busy0", valid_count - n0, busy);
      end
   endtask

   task automatic test_enable_abort;
      int  k;
      int  at;
      int  n0;
      bit  got;
      vin_code = 8'h3C;
      exp_q.push_back(8'h3C);
      start_conv(k);
      tick(9);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_valid(got, at);
      checks++;
      if (!got || (at - k) != LAT) begin errors++; $display("FAIL busy_start_latency got=%0d required=%0d", got ? at - k : -1, LAT); end
      n0 = valid_count;
      tick(60);
      checks++;
      if (valid_count != n0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_queued got=extra%0d/busy%b required=extra0/busy0", valid_count - n0, busy);
      end
      vin_code = 8'h77;
      start_conv(k);
      tick(19);
      enable = 1'b0;
      tick(1);
      checks++;
      if (dac_code !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got=dac%02h/busy%b required=dac00/busy0", dac_code, busy);
      end
      checks++;
      if (r2r_successive_out !== 8'h3C) begin errors++; $display("FAIL abort_hold got=%02h required=3c", r2r_successive_out); end
      n0 = valid_count;
      start = 1'b1;
      tick(3);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_disabled got=busy%b required=busy0", busy); end
      start  = 1'b0;
      enable = 1'b1;
      tick(60);
      checks++;
      if (valid_count != n0 || r2r_successive_out !== 8'h3C) begin
         errors++;
         $display("FAIL abort_no_result got=extra%0d/out%02h required=extra0/out3c", valid_count - n0, r2r_successive_out);
      end
   endtask

   task automatic test_reset_mid;
      int  k;
      int  at;
      int  n0;
      bit  got;
      vin_code = 8'h99;
      start_conv(k);
      tick(2);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (dac_code !== 8'h00 || busy !== 1'b0 || result_valid !== 1'b0 || r2r_successive_out !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got=dac%02h/busy%b/valid%b/out%02h required=all0",
                  dac_code, busy, result_valid, r2r_successive_out);
      end
      #20;
      reset_n = 1'b1;
      n0 = valid_count;
      tick(60);
      checks++;
      if (valid_count != n0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got=extra%0d/busy%b required=extra0/busy0", valid_count - n0, busy);
      end
      vin_code = 8'h5A;
      exp_q.push_back(8'h5A);
      start_conv(k);
      wait_valid(got, at);
      checks++;
      if (!got || (at - k) != LAT) begin errors++; $display("FAIL post_reset_latency got=%0d required=%0d", got ? at - k : -1, LAT); end
      tick(3);
   endtask

   initial begin
      test_reset();
      test_trial_sequence();
      test_boundaries();
      test_continuous();
      test_enable_abort();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL results_outstanding got=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/r2r_sar_controller.md
Name: r2r_sar_controller

Overview:
- Successive-approximation conversion engine for the R2R ADC path.
- Drives the 8-bit R2R ladder code and samples the external analog comparator, one bit per trial, MSB first.
- Publishes the held conversion result that feeds the R2R SUCCESSIVE input of the regular/successive output selector, upstream of the averaging and scaling stages.
- Supports one-shot and continuous conversion.

Parameters:
- WIDTH, 8, result and DAC code width in bits.
- SETTLE_CYCLES, 1000, clocks held per trial before the comparator is sampled; covers R2R settling plus 2-flop sync delay; must be >= 3.

Ports:
- clk  input  1  system clock (100 MHz)
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  converter enabled; low aborts any conversion
- start  input  1  one-shot request, sampled only in IDLE
- continuous  input  1  when high, the next conversion starts automatically after DONE
- comparator_in  input  1  raw comparator, asynchronous to clk; 1 = Vin >= Vdac
- dac_code  output  WIDTH  code driven onto the R2R ladder
- r2r_successive_out  output  WIDTH  last completed result, held until the next completion
- result_valid  output  1  one-clock pulse when r2r_successive_out updates
- busy  output  1  high in SET_BIT, SETTLE and COMPARE

Behaviour:
- Reset (async, reset_n low): state=IDLE, dac_code=0, r2r_successive_out=0, result_valid=0, busy=0, sync flops=0, bit index=WIDTH-1, settle counter=0.
- comparator_in passes through a 2-flop synchronizer; only comp_sync is used.
- FSM states: IDLE, SET_BIT, SETTLE, COMPARE, DONE.
- IDLE: dac_code=0.
  - Go to SET_BIT when enable & (start | continuous).
  - Load bit index=WIDTH-1 and trial code=0.
- SET_BIT (1 clk): dac_code = trial | (1<<idx); clear the settle counter.
- SETTLE (SETTLE_CYCLES clks): dac_code held; counter increments; leave when counter==SETTLE_CYCLES-1.
- COMPARE (1 clk):
  - If comp_sync=1, the bit stays set; otherwise it is cleared. Result becomes the new trial.
  - If idx==0, go to DONE; else idx-1 and go to SET_BIT.
- DONE (1 clk):
  - r2r_successive_out=trial; result_valid=1; dac_code=trial.
  - Next state: SET_BIT (fresh trial, idx=WIDTH-1) if enable & continuous, else IDLE.
- Latency: start sampled at edge k, result_valid high in cycle k+1+WIDTH*(SETTLE_CYCLES+2).
  - With SETTLE_CYCLES=4 this is 49 clks.
  - In continuous mode the result period is WIDTH*(SETTLE_CYCLES+2)+1 clks.
- start while busy or in DONE: ignored, not queued.
- enable low in any non-IDLE state:
  - Next state is IDLE and dac_code=0.
  - r2r_successive_out keeps its previous value; no result_valid.
- enable low and start high together: no conversion.
- continuous falling mid-conversion: the current conversion completes, then the FSM returns to IDLE.
- Boundary inputs:
  - Vin >= full scale gives 0xFF (every trial kept).
  - Vin below LSB gives 0x00.
  - No overflow or wrap; the code is bitwise, not arithmetic.
- reset_n asserted mid-conversion: immediate return to reset values. The first conversion after release needs a new start or continuous.

Decomposition:
- Package adc_pkg holds:
  - sar_state_t enum (IDLE, SET_BIT, SETTLE, COMPARE, DONE).
  - ADC_WIDTH=8.
  - DEFAULT_SETTLE_CYCLES=1000.
- Sub-module sync_2ff (1-bit, clk, reset_n), reusable for the PWM comparator path.
- Settle counter width is $clog2(SETTLE_CYCLES) inline; no separate counter module.

Test Plan:
- Bench conditions: SETTLE_CYCLES=4. Comparator model = (vin_code >= dac_code), applied directly.
- vin=0xA5, start pulse → dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result_valid one clk, 49 clks after start; r2r_successive_out=0xA5.
- vin=0x00 then vin=0xFF, one-shot each → results 0x00 and 0xFF; busy low and dac_code=0 in IDLE afterwards.
- continuous=1, vin 0x3C then 0x81 mid-stream → back-to-back result_valid pulses 49 clks apart; outputs 0x3C, then 0x81 on the first conversion starting after the change.
- enable dropped at clk 20 of a conversion with prior result 0x3C → next clk IDLE, dac_code=0, no result_valid, r2r_successive_out stays 0x3C; start pulse while busy ignored.
- reset_n pulsed low mid-SETTLE → all outputs 0 asynchronously; after release no activity until start; the new conversion of vin=0x5A yields 0x5A.
